i2c_codec_responder: RTL and testbench

- Synthesizable I2C write-only target that behaves as the WM8731 control port: it ACKs the codec address and captures 7-bit register address plus 9-bit data words into a register file.
- Runs on the CLOCK31_5 domain and connects to the AUD_I2C_SCLK and AUD_I2C_SDAT nets on an on-FPGA loopback build.
- Used to check the codec configuration sequence in hardware and in simulation without a real codec.

---
 rtl/i2c_codec_responder.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_codec_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_responder.sv
// Write-only I2C target standing in for the WM8731 control port: ACKs the codec
// address and commits 7-bit address / 9-bit data words into a small register file.
module i2c_codec_responder #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         NUM_REGS    = 10,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       CLOCK31_5,
    input  logic       resetN,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_drive_low,
    output logic       wr_valid,
    output logic [3:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       addr_err,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, BYTE1, ACK1, BYTE2, ACK2, IGNORE
    } state_t;

    localparam logic [7:0] WRITE_BYTE = {DEV_ADDR, 1'b0};

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_prev, sda_prev;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]             bit_cnt;
    logic [7:0]             shift;
    logic [7:0]             reg_byte;
    logic                   drive_next, bit_clr, commit;
    logic [6:0]             commit_addr;
    logic [8:0]             commit_data;
    logic [8:0]             regs [NUM_REGS];

    function automatic logic [8:0] reg_default(input int idx);
        case (idx)
            0, 1:    return 9'h097;
            2, 3:    return 9'h079;
            4:       return 9'h00A;
            5:       return 9'h008;
            6:       return 9'h09F;
            7:       return 9'h00A;
            default: return 9'h000;
        endcase
    endfunction

    // Both lines idle high, so the synchronizers reset to 1 to avoid a false START.
    always_ff @(posedge CLOCK31_5 or negedge resetN) begin
        if (!resetN) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= SYNC_STAGES'({scl_sync, scl_in});
            sda_sync <= SYNC_STAGES'({sda_sync, sda_in});
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

    assign commit_addr = reg_byte[7:1];
    assign commit_data = {reg_byte[0], shift[6:0], sda_s};

    always_ff @(posedge CLOCK31_5 or negedge resetN) begin
        if (!resetN) begin
            state         <= IDLE;
            sda_drive_low <= 1'b0;
        end else begin
            state         <= state_next;
            sda_drive_low <= drive_next;
        end
    end

    // ACK phases are entered and left on SCL falls, so SDA only moves while SCL is low.
    always_comb begin
        state_next = state;
        drive_next = sda_drive_low;
        bit_clr    = 1'b0;
        commit     = 1'b0;
        if (start_det) begin
            state_next = ADDR;
            drive_next = 1'b0;
            bit_clr    = 1'b1;
        end else if (stop_det) begin
            state_next = IDLE;
            drive_next = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_fall && bit_cnt == 4'd8) begin
                        if (shift == WRITE_BYTE) begin
                            state_next = ADDR_ACK;
                            drive_next = 1'b1;
                        end else begin
                            state_next = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        state_next = BYTE1;
                        drive_next = 1'b0;
                        bit_clr    = 1'b1;
                    end
                end
                BYTE1: begin
                    if (scl_fall && bit_cnt == 4'd8) begin
                        state_next = ACK1;
                        drive_next = 1'b1;
                    end
                end
                ACK1: begin
                    if (scl_fall) begin
                        state_next = BYTE2;
                        drive_next = 1'b0;
                        bit_clr    = 1'b1;
                    end
                end
                BYTE2: begin
                    commit = scl_rise && bit_cnt == 4'd7;
                    if (scl_fall && bit_cnt == 4'd8) begin
                        state_next = ACK2;
                        drive_next = 1'b1;
                    end
                end
                ACK2: begin
                    if (scl_fall) begin
                        state_next = IGNORE;
                        drive_next = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK31_5 or negedge resetN) begin
        if (!resetN) begin
            bit_cnt  <= '0;
            shift    <= '0;
            reg_byte <= '0;
        end else begin
            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (scl_rise && bit_cnt != 4'd8 &&
                         (state == ADDR || state == BYTE1 || state == BYTE2)) begin
                shift   <= {shift[6:0], sda_s};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (state == BYTE1 && state_next == ACK1)
                reg_byte <= shift;
        end
    end

    // Address 15 is the codec's reset register: it restores every default.
    always_ff @(posedge CLOCK31_5 or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= reg_default(i);
            wr_valid <= 1'b0;
            addr_err <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            rd_data  <= '0;
            busy     <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            addr_err <= 1'b0;
            if (commit) begin
                if (32'(commit_addr) < NUM_REGS) begin
                    regs[commit_addr[3:0]] <= commit_data;
                    wr_valid <= 1'b1;
                    wr_addr  <= commit_addr[3:0];
                    wr_data  <= commit_data;
                end else if (commit_addr == 7'd15) begin
                    for (int i = 0; i < NUM_REGS; i++)
                        regs[i] <= reg_default(i);
                    wr_valid <= 1'b1;
                    wr_addr  <= 4'd15;
                    wr_data  <= commit_data;
                end else begin
                    addr_err <= 1'b1;
                end
            end
            rd_data <= (32'(rd_addr) < NUM_REGS) ? regs[rd_addr] : 9'h000;
            if (start_det)
                busy <= 1'b1;
            else if (stop_det)
                busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed bench for i2c_codec_responder: a bit-banged I2C master with an
// open-drain SDA model, pulse monitors and hand-computed register expectations.
module tb_i2c_codec_responder;

    logic       CLOCK31_5 = 1'b0;
    logic       resetN;
    logic       scl_m, sda_m;
    logic       sda_drive_low, wr_valid, addr_err, busy;
    logic [3:0] wr_addr, rd_addr;
    logic [8:0] wr_data, rd_data;
    wire        sda_bus = sda_m & ~sda_drive_low;

    int errors = 0;
    int checks = 0;

    int         wv_total = 0, err_total = 0, drive_total = 0;
    logic [3:0] last_wa = '0;
    logic [8:0] last_wd = '0;

    localparam logic [8:0] DEFS [10] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                                         9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};

    i2c_codec_responder dut (
        .CLOCK31_5    (CLOCK31_5),
        .resetN       (resetN),
        .scl_in       (scl_m),
        .sda_in       (sda_bus),
        .sda_drive_low(sda_drive_low),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .addr_err     (addr_err),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy)
    );

    always #5 CLOCK31_5 = ~CLOCK31_5;

    // Pulse monitors sample on the falling edge, away from the DUT's active edge.
    always @(negedge CLOCK31_5) begin
        if (wr_valid) begin
            wv_total++;
            last_wa = wr_addr;
            last_wd = wr_data;
        end
        if (addr_err)
            err_total++;
        if (sda_drive_low)
            drive_total++;
    end

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLOCK31_5);
    endtask

    task automatic send_bit(input logic b);
        wait_clk(5);
        sda_m = b;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(10);
        scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--)
            send_bit(b[i]);
    endtask

    task automatic ack_bit(output logic ack);
        wait_clk(5);
        sda_m = 1'b1;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(5);
        ack = !sda_bus;
        wait_clk(5);
        scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clk(10);
        sda_m = 1'b0;
        wait_clk(10);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(5);
        sda_m = 1'b0;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(10);
        sda_m = 1'b1;
        wait_clk(10);
    endtask

    task automatic read_reg(input logic [3:0] idx, output logic [8:0] val);
        rd_addr = idx;
        wait_clk(2);
        val = rd_data;
    endtask

    // One complete three-byte write transaction; returns how many bytes were ACKed.
    task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2, output int acks);
        logic a;
        acks = 0;
        i2c_start();
        send_byte(b0); ack_bit(a); acks += int'(a);
        send_byte(b1); ack_bit(a); acks += int'(a);
        send_byte(b2); ack_bit(a); acks += int'(a);
        i2c_stop();
    endtask

    initial begin
        int         acks, wv0, err0, drv0, n;
        logic       a;
        logic [8:0] v;

        resetN  = 1'b0;
        scl_m   = 1'b1;
        sda_m   = 1'b1;
        rd_addr = 4'd0;
        wait_clk(5);
        checkOutput("rst_sda_drive_low", 16'(sda_drive_low), 16'h0);
        checkOutput("rst_wr_valid", 16'(wr_valid), 16'h0);
        checkOutput("rst_addr_err", 16'(addr_err), 16'h0);
        checkOutput("rst_wr_addr", 16'(wr_addr), 16'h0);
        checkOutput("rst_wr_data", 16'(wr_data), 16'h0);
        checkOutput("rst_rd_data", 16'(rd_data), 16'h0);
        checkOutput("rst_busy", 16'(busy), 16'h0);
        resetN = 1'b1;
        wait_clk(5);
        for (int i = 0; i < 10; i++) begin
            read_reg(4'(i), v);
            checkOutput($sformatf("default_R%0d", i), 16'(v), 16'(DEFS[i]));
        end
        read_reg(4'd12, v);
        checkOutput("read_out_of_range", 16'(v), 16'h0);

        $display("[TB] write R6 = 0x000");
        wv0 = wv_total;
        applyStimulus(8'h34, 8'h0C, 8'h00, acks);
        checkOutput("r6_acks", 16'(acks), 16'd3);
        checkOutput("r6_wr_valid_count", 16'(wv_total - wv0), 16'd1);
        checkOutput("r6_wr_addr", 16'(last_wa), 16'd6);
        checkOutput("r6_wr_data", 16'(last_wd), 16'h000);
        read_reg(4'd6, v);
        checkOutput("r6_read", 16'(v), 16'h000);
        checkOutput("busy_after_stop", 16'(busy), 16'h0);

        $display("[TB] write R0 = 0x117 then reset register");
        applyStimulus(8'h34, 8'h01, 8'h17, acks);
        read_reg(4'd0, v);
        checkOutput("r0_read", 16'(v), 16'h117);
        wv0 = wv_total;
        applyStimulus(8'h34, 8'h1E, 8'h00, acks);
        checkOutput("rst_reg_acks", 16'(acks), 16'd3);
        checkOutput("rst_reg_wr_valid_count", 16'(wv_total - wv0), 16'd1);
        checkOutput("rst_reg_wr_addr", 16'(last_wa), 16'd15);
        checkOutput("rst_reg_wr_data", 16'(last_wd), 16'h000);
        read_reg(4'd0, v);
        checkOutput("r0_after_reset_reg", 16'(v), 16'h097);
        read_reg(4'd6, v);
        checkOutput("r6_after_reset_reg", 16'(v), 16'h09F);

        $display("[TB] wrong address 0x36 and read request 0x35");
        wv0  = wv_total;
        drv0 = drive_total;
        i2c_start();
        send_byte(8'h36); ack_bit(a);
        checkOutput("addr36_ack", 16'(a), 16'h0);
        send_byte(8'h0C); ack_bit(a);
        checkOutput("addr36_busy", 16'(busy), 16'h1);
        i2c_stop();
        checkOutput("addr36_busy_after_stop", 16'(busy), 16'h0);
        i2c_start();
        send_byte(8'h35); ack_bit(a);
        checkOutput("addr35_ack", 16'(a), 16'h0);
        send_byte(8'h0C); ack_bit(a);
        checkOutput("addr35_busy", 16'(busy), 16'h1);
        i2c_stop();
        checkOutput("foreign_drive_cycles", 16'(drive_total - drv0), 16'd0);
        checkOutput("foreign_wr_valid_count", 16'(wv_total - wv0), 16'd0);

        $display("[TB] unimplemented address 12");
        wv0  = wv_total;
        err0 = err_total;
        applyStimulus(8'h34, 8'h18, 8'h55, acks);
        checkOutput("bad_addr_acks", 16'(acks), 16'd3);
        checkOutput("bad_addr_err_count", 16'(err_total - err0), 16'd1);
        checkOutput("bad_addr_wr_valid_count", 16'(wv_total - wv0), 16'd0);
        for (int i = 0; i < 10; i++) begin
            read_reg(4'(i), v);
            checkOutput($sformatf("unchanged_R%0d", i), 16'(v), 16'(DEFS[i]));
        end

        $display("[TB] aborted transfer then R4 = 0x012");
        wv0 = wv_total;
        i2c_start();
        send_byte(8'h34); ack_bit(a);
        send_byte(8'h08); ack_bit(a);
        i2c_stop();
        checkOutput("abort_wr_valid_count", 16'(wv_total - wv0), 16'd0);
        read_reg(4'd4, v);
        checkOutput("abort_r4", 16'(v), 16'h00A);
        applyStimulus(8'h34, 8'h08, 8'h12, acks);
        checkOutput("r4_wr_valid_count", 16'(wv_total - wv0), 16'd1);
        read_reg(4'd4, v);
        checkOutput("r4_read", 16'(v), 16'h012);

        $display("[TB] reset during address ACK");
        i2c_start();
        send_byte(8'h34);
        n = 0;
        while (!sda_drive_low && n < 20) begin
            wait_clk(1);
            n++;
        end
        checkOutput("ack_drive_before_reset", 16'(sda_drive_low), 16'h1);
        #2 resetN = 1'b0;
        #1 checkOutput("async_release", 16'(sda_drive_low), 16'h0);
        wait_clk(3);
        resetN = 1'b1;
        i2c_stop();
        read_reg(4'd4, v);
        checkOutput("r4_after_reset", 16'(v), 16'h00A);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
